// File: rtl/wbm_cmd_master.sv
// Single-outstanding command-to-Wishbone classic master (IDLE -> BUS -> RESP).
// Optional bus timeout is compiled in when WBM_TIMEOUT_EN is defined.
module wbm_cmd_master #(
  parameter int BUS_DATA_WIDTH = 32,
  parameter int BUS_ADDR_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int BYTE_ENABLES = BUS_DATA_WIDTH / 8
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_we_i,
  input  logic [BUS_ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [BUS_DATA_WIDTH-1:0] cmd_dat_i,
  input  logic [BYTE_ENABLES-1:0]   cmd_sel_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [BUS_DATA_WIDTH-1:0] rsp_dat_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output logic                      wbm_cyc_o,
  output logic                      wbm_stb_o,
  output logic                      wbm_we_o,
  output logic [BYTE_ENABLES-1:0]   wbm_sel_o,
  output logic [BUS_ADDR_WIDTH-1:0] wbm_adr_o,
  output logic [BUS_DATA_WIDTH-1:0] wbm_dat_o,
  input  logic [BUS_DATA_WIDTH-1:0] wbm_dat_i,
  input  logic                      wbm_ack_i,
  input  logic                      wbm_err_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state;

  // Blocking on ack keeps a slave that stretches ack past stb from
  // terminating the next command early.
  assign cmd_ready_o = (state == IDLE) && !wbm_ack_i;

`ifdef WBM_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        expired;
  assign expired = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign rsp_timeout_o = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
`ifdef WBM_TIMEOUT_EN
      rsp_timeout_o <= 1'b0;
      tmo_cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= cmd_we_i;
            wbm_sel_o <= cmd_sel_i;
            wbm_adr_o <= cmd_adr_i;
            wbm_dat_o <= cmd_dat_i;
`ifdef WBM_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
            state     <= BUS;
          end
        end
        BUS: begin
          if (wbm_ack_i || wbm_err_i) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= wbm_err_i;
            // Only a clean read ack returns data; err wins over a coincident ack.
            rsp_dat_o   <= (wbm_ack_i && !wbm_err_i && !wbm_we_o) ? wbm_dat_i : '0;
`ifdef WBM_TIMEOUT_EN
            rsp_timeout_o <= 1'b0;
`endif
            state       <= RESP;
          end
`ifdef WBM_TIMEOUT_EN
          else if (expired) begin
            wbm_cyc_o     <= 1'b0;
            wbm_stb_o     <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_err_o     <= 1'b1;
            rsp_timeout_o <= 1'b1;
            rsp_dat_o     <= '0;
            state         <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wbm_cmd_master.sv
// Randomized bench for wbm_cmd_master: bench-owned slave memory predicts every response.
// Define WBM_TIMEOUT_EN for both files to exercise the timeout build (TIMEOUT_CYCLES=4).
module tb_wbm_cmd_master;
  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int BE  = DW / 8;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [AW-1:0] cmd_adr_i;
  logic [DW-1:0] cmd_dat_i;
  logic [BE-1:0] cmd_sel_i;
  logic          rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_timeout_o;
  logic [DW-1:0] rsp_dat_o;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [BE-1:0] wbm_sel_o;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o, wbm_dat_i;
  logic          wbm_ack_i, wbm_err_i;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  wbm_cmd_master #(
    .BUS_DATA_WIDTH(DW),
    .BUS_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [BE-1:0] sel);
    logic [DW-1:0] r = old;
    for (int b = 0; b < BE; b++) if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Present one command at a negedge; returns just after the accepting edge.
  task automatic issue(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                       input logic [BE-1:0] sel);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_idle", cmd_ready_o, 1);
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    cmd_we_i  = 1'($urandom);
    cmd_adr_i = AW'($urandom);
    cmd_dat_i = DW'($urandom);
    cmd_sel_i = BE'($urandom);
  endtask

  task automatic check_bus(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                           input logic [BE-1:0] sel);
    check("bus_cyc", wbm_cyc_o, 1);
    check("bus_stb", wbm_stb_o, 1);
    check("bus_we", wbm_we_o, we);
    check("bus_adr", wbm_adr_o, adr);
    check("bus_dat", wbm_dat_o, dat);
    check("bus_sel", wbm_sel_o, sel);
  endtask

  // kind: 0 ack, 1 err, 2 ack+err. hold: extra cycles the slave keeps its termination high.
  task automatic txn(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                     input logic [BE-1:0] sel, input int lat, input int kind, input int hold,
                     input int rsp_wait);
    logic [DW-1:0] exp_dat;
    logic          exp_err;
    logic          done = 1'b0;
    exp_err = (kind != 0);
    exp_dat = (!exp_err && !we) ? mem[adr] : '0;
    issue(we, adr, dat, sel);
    for (int i = 0; i <= lat; i++) begin
      @(negedge clk);
      check_bus(we, adr, dat, sel);
      check("rsp_valid_in_bus", rsp_valid_o, 0);
      wbm_dat_i = DW'($urandom);
      if (i == lat) begin
        wbm_ack_i = (kind != 1);
        wbm_err_i = (kind != 0);
        if (!we) wbm_dat_i = mem[adr];
      end
    end
    if (we && !exp_err) mem[adr] = merge(mem[adr], dat, sel);
    for (int k = 0; k < rsp_wait + hold + 3; k++) begin
      @(negedge clk);
      if (rsp_ready_i) begin
        done = 1'b1;
        rsp_ready_i = 1'b0;
      end
      check("cyc_after_term", wbm_cyc_o || wbm_stb_o, 0);
      if (wbm_ack_i) check("ready_while_ack", cmd_ready_o, 0);
      if (!done) begin
        check("rsp_valid", rsp_valid_o, 1);
        check("rsp_err", rsp_err_o, exp_err);
        check("rsp_dat", rsp_dat_o, exp_dat);
        check("rsp_timeout", rsp_timeout_o, 0);
      end else begin
        check("rsp_valid_cleared", rsp_valid_o, 0);
      end
      wbm_ack_i = (k < hold) && (kind != 1);
      wbm_err_i = (k < hold) && (kind != 0);
      wbm_dat_i = DW'($urandom);
      if (!done && k >= rsp_wait) rsp_ready_i = 1'b1;
    end
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] a [3];
    logic [DW-1:0] d [3];
    int n, bus_seen, rsp_seen, sent;
    logic prev_cyc, accept;

    rst = 1'b1;
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_dat_i = '0; cmd_sel_i = '0;
    rsp_ready_i = 1'b0; wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, rsp_valid_o,
                          rsp_err_o, rsp_timeout_o}, 0);
    check("rst_adr", wbm_adr_o, 0);
    check("rst_dat", wbm_dat_o, 0);
    check("rst_rsp_dat", rsp_dat_o, 0);
    check("rst_cmd_ready", cmd_ready_o, 1);
    rst = 1'b0;

    // Write with ack one cycle late, stretched one cycle.
    txn(1'b1, 8'h00, 32'hDEADBEEF, 4'hF, 1, 0, 1, 0);
    // Read with the response held off for 5 cycles.
    mem[0] = 32'h12345678;
    txn(1'b0, 8'h00, '0, 4'hF, 0, 0, 0, 5);
    // Coincident ack and err on a read.
    txn(1'b0, AW'($urandom), '0, 4'hF, 0, 2, 0, 1);
    // Ack stretched into IDLE.
    txn(1'b0, AW'($urandom), '0, 4'hF, 0, 0, 2, 0);

    // Silent slave.
    issue(1'b0, 8'h11, '0, 4'hF);
`ifdef WBM_TIMEOUT_EN
    n = 0;
    @(negedge clk);
    while (wbm_cyc_o && wbm_stb_o && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("tmo_bus_cycles", n, TMO);
    check("tmo_rsp_valid", rsp_valid_o, 1);
    check("tmo_rsp_err", rsp_err_o, 1);
    check("tmo_rsp_timeout", rsp_timeout_o, 1);
    check("tmo_rsp_dat", rsp_dat_o, 0);
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    check("tmo_rsp_cleared", rsp_valid_o, 0);
`else
    n = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (wbm_cyc_o && wbm_stb_o && !rsp_valid_o) n++;
    end
    check("no_tmo_bus_held", n, 120);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("no_tmo_abort", wbm_cyc_o || rsp_valid_o, 0);
`endif

    // Reset during BUS aborts without any response.
    issue(1'b1, 8'h22, DW'($urandom), 4'hF);
    @(negedge clk);
    check("abort_in_bus", wbm_cyc_o, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_cyc_stb", {wbm_cyc_o, wbm_stb_o}, 0);
    wbm_ack_i = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wbm_ack_i = 1'b0;
      if (rsp_valid_o || wbm_cyc_o) n++;
    end
    check("abort_no_rsp", n, 0);
    txn(1'b0, 8'h22, '0, 4'hF, 1, 0, 0, 0);

    // Back-to-back writes with an immediately acking slave.
    for (int i = 0; i < 3; i++) begin
      a[i] = AW'($urandom);
      d[i] = DW'($urandom);
    end
    bus_seen = 0; rsp_seen = 0; sent = 0; prev_cyc = 1'b0;
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = a[0]; cmd_dat_i = d[0]; cmd_sel_i = 4'b0101;
    rsp_ready_i = 1'b1;
    for (int c = 0; c < 30; c++) begin
      wbm_ack_i = wbm_cyc_o && wbm_stb_o;
      if (wbm_cyc_o && !prev_cyc) begin
        if (bus_seen < 3) begin
          check("b2b_sel", wbm_sel_o, 4'b0101);
          check("b2b_adr", wbm_adr_o, a[bus_seen]);
          check("b2b_dat", wbm_dat_o, d[bus_seen]);
        end
        bus_seen++;
      end
      prev_cyc = wbm_cyc_o;
      if (rsp_valid_o) begin
        check("b2b_rsp", {rsp_err_o, rsp_dat_o}, 0);
        rsp_seen++;
      end
      if (wbm_cyc_o && rsp_valid_o) check("b2b_overlap", 1, 0);
      #1 accept = cmd_valid_i && cmd_ready_o;
      @(posedge clk); #1;
      if (accept) begin
        sent++;
        if (sent == 3) cmd_valid_i = 1'b0;
        else begin
          cmd_adr_i = a[sent];
          cmd_dat_i = d[sent];
        end
      end
      @(negedge clk);
    end
    check("b2b_bus_count", bus_seen, 3);
    check("b2b_rsp_count", rsp_seen, 3);
    rsp_ready_i = 1'b0;
    wbm_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) mem[a[i]] = merge(mem[a[i]], d[i], 4'b0101);

    // Randomized mix; latency up to TMO-1 so ack may coincide with timeout expiry.
    for (int t = 0; t < 40; t++) begin
      int kind;
      kind = ($urandom_range(0, 5) < 4) ? 0 : int'($urandom_range(1, 2));
      txn(1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom), BE'($urandom),
          int'($urandom_range(0, TMO - 1)), kind, int'($urandom_range(0, 2)),
          int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
